// File: rtl/rr_muxn.sv
// Registered N-way multiplexer with a round-robin arbiter and valid/ready handshakes on every channel.
// Define RR_MUXN_FIXED_PRIORITY_EN to replace round-robin with fixed lowest-index-wins priority.
module rr_muxn #(
  parameter  int INPUT_NUM  = 4,
  parameter  int INPUT_SIZE = 8,
  localparam int S          = $clog2(INPUT_NUM)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [INPUT_NUM*INPUT_SIZE-1:0] in,
  input  logic [INPUT_NUM-1:0]            in_valid,
  output logic [INPUT_NUM-1:0]            in_ready,
  output logic [INPUT_SIZE-1:0]           out,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [S-1:0]                    out_sel
);

  logic [INPUT_SIZE-1:0] r_out;
  logic                  r_outValid;
  logic [S-1:0]          r_outSel;

  logic [S-1:0]          w_ptr;
  logic                  w_any;
  logic                  w_load;
  logic                  w_take;
  logic                  w_hiFound;
  logic [S-1:0]          w_hiIdx;
  logic [S-1:0]          w_loIdx;
  logic [S-1:0]          w_grant;
  logic [INPUT_SIZE-1:0] w_data;

  assign w_any  = |in_valid;
  assign w_load = !r_outValid || out_ready;
  assign w_take = rst_n && w_load && w_any;

  // Channels at or above the pointer outrank those below it; the lowest index wins within each group.
  always_comb begin
    w_hiFound = 1'b0;
    w_hiIdx   = '0;
    w_loIdx   = '0;
    for (int i = INPUT_NUM - 1; i >= 0; i--) begin
      if (in_valid[i]) begin
        if (i >= int'(w_ptr)) begin
          w_hiFound = 1'b1;
          w_hiIdx   = S'(i);
        end else begin
          w_loIdx   = S'(i);
        end
      end
    end
    w_grant = w_hiFound ? w_hiIdx : w_loIdx;
  end

  always_comb begin
    w_data = '0;
    for (int i = 0; i < INPUT_NUM; i++) begin
      if (w_grant == S'(i)) begin
        w_data = in[i*INPUT_SIZE +: INPUT_SIZE];
      end
    end
  end

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < INPUT_NUM; i++) begin
      in_ready[i] = w_take && (w_grant == S'(i));
    end
  end

`ifdef RR_MUXN_FIXED_PRIORITY_EN
  assign w_ptr = '0;
`else
  logic [S-1:0] r_ptr;
  logic [S-1:0] w_nextPtr;

  // Explicit wrap so non-power-of-two widths never land on an unused index.
  assign w_nextPtr = (w_grant == S'(INPUT_NUM - 1)) ? '0 : w_grant + 1'b1;
  assign w_ptr     = r_ptr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_take) begin
      r_ptr <= w_nextPtr;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out      <= '0;
      r_outValid <= 1'b0;
      r_outSel   <= '0;
    end else if (w_load) begin
      if (w_any) begin
        r_out      <= w_data;
        r_outSel   <= w_grant;
        r_outValid <= 1'b1;
      end else begin
        r_outValid <= 1'b0;
      end
    end
  end

  assign out       = r_out;
  assign out_valid = r_outValid;
  assign out_sel   = r_outSel;

endmodule

// File: tb/tb_rr_muxn.sv
// Self-checking bench for rr_muxn: a 4x8 instance checked against a behavioural arbiter model,
// plus a 3x16 instance checking non-power-of-two pointer wrap.
module tb_rr_muxn;

  localparam int NA = 4;
  localparam int WA = 8;
  localparam int NB = 3;
  localparam int WB = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstN;

  logic [NA-1:0]    aValid;
  logic [NA-1:0]    aReady;
  logic [WA-1:0]    aData [NA];
  logic [NA*WA-1:0] aIn;
  logic [WA-1:0]    aOut;
  logic             aOutValid;
  logic             aOutReady;
  logic [1:0]       aSel;

  logic [NB-1:0]    bValid;
  logic [NB-1:0]    bReady;
  logic [WB-1:0]    bData [NB];
  logic [NB*WB-1:0] bIn;
  logic [WB-1:0]    bOut;
  logic             bOutValid;
  logic             bOutReady;
  logic [1:0]       bSel;

  assign aIn = {aData[3], aData[2], aData[1], aData[0]};
  assign bIn = {bData[2], bData[1], bData[0]};

  rr_muxn #(.INPUT_NUM(NA), .INPUT_SIZE(WA)) dutA (
    .clk(clk), .rst_n(rstN), .in(aIn), .in_valid(aValid), .in_ready(aReady),
    .out(aOut), .out_valid(aOutValid), .out_ready(aOutReady), .out_sel(aSel)
  );

  rr_muxn #(.INPUT_NUM(NB), .INPUT_SIZE(WB)) dutB (
    .clk(clk), .rst_n(rstN), .in(bIn), .in_valid(bValid), .in_ready(bReady),
    .out(bOut), .out_valid(bOutValid), .out_ready(bOutReady), .out_sel(bSel)
  );

  int nChecks = 0;
  int nFails  = 0;

  // Reference state for dutA: priority pointer and the one-word output register.
  int          mPtr = 0;
  logic        mOV  = 1'b0;
  logic [WA-1:0] mOut = '0;
  int          mSel = 0;

  function automatic int pick(input logic [NA-1:0] v, input int p);
    for (int k = 0; k < NA; k++) begin
      int idx;
      idx = (p + k) % NA;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [NA-1:0] expReadyA();
    logic [NA-1:0] r;
    int g;
    r = '0;
    if (rstN && (!mOV || aOutReady)) begin
      g = pick(aValid, mPtr);
      if (g >= 0) r[g] = 1'b1;
    end
    return r;
  endfunction

  task automatic tickA(output int granted);
    logic ld;
    int g;
    ld = !mOV || aOutReady;
    g = pick(aValid, mPtr);
    granted = -1;
    @(posedge clk);
    if (!rstN) begin
      mOV = 1'b0; mOut = '0; mSel = 0; mPtr = 0;
    end else if (ld) begin
      if (g >= 0) begin
        mOut = aData[g];
        mSel = g;
        mOV = 1'b1;
        granted = g;
`ifndef RR_MUXN_FIXED_PRIORITY_EN
        mPtr = (g + 1) % NA;
`endif
      end else begin
        mOV = 1'b0;
      end
    end
    #1;
  endtask

  task automatic doReset();
    int g;
    rstN = 1'b0;
    aValid = '0;
    #2;
    tickA(g);
    rstN = 1'b1;
  endtask

  task automatic test_reset();
    int g;
    rstN = 1'b0;
    aValid = '1;
    aOutReady = 1'b1;
    bValid = '1;
    bOutReady = 1'b1;
    for (int i = 0; i < NA; i++) aData[i] = 8'hA0 + 8'(i);
    for (int i = 0; i < NB; i++) bData[i] = 16'hB000 + 16'(i);
    for (int c = 0; c < 3; c++) begin
      #2;
      nChecks++;
      if (aReady !== '0 || bReady !== '0) begin
        nFails++;
        $display("[TB] FAIL reset_ready cyc=%0d got a=%b b=%b exp 0", c, aReady, bReady);
      end
      tickA(g);
      nChecks++;
      if (aOutValid !== 1'b0 || aOut !== '0 || aSel !== '0) begin
        nFails++;
        $display("[TB] FAIL reset_outA cyc=%0d got v=%b d=%h s=%0d exp 0/00/0", c, aOutValid, aOut, aSel);
      end
      nChecks++;
      if (bOutValid !== 1'b0 || bOut !== '0 || bSel !== '0) begin
        nFails++;
        $display("[TB] FAIL reset_outB cyc=%0d got v=%b d=%h s=%0d exp 0/0000/0", c, bOutValid, bOut, bSel);
      end
    end
    bValid = '0;
  endtask

  task automatic test_fairness();
    int g;
    int es;
    logic [NA-1:0] expR;
    rstN = 1'b1;
    aValid = '1;
    aOutReady = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #2;
      expR = expReadyA();
      nChecks++;
      if (aReady !== expR) begin
        nFails++;
        $display("[TB] FAIL fair_ready cyc=%0d got=%b exp=%b", c, aReady, expR);
      end
      tickA(g);
`ifdef RR_MUXN_FIXED_PRIORITY_EN
      es = 0;
`else
      es = c % NA;
`endif
      nChecks++;
      if (aOutValid !== 1'b1 || aSel !== 2'(es) || aOut !== 8'hA0 + 8'(es)) begin
        nFails++;
        $display("[TB] FAIL fair_seq cyc=%0d got v=%b d=%h s=%0d exp v=1 d=%h s=%0d",
                 c, aOutValid, aOut, aSel, 8'hA0 + 8'(es), es);
      end
    end
  endtask

  task automatic test_sparse();
    int g;
    logic [NA-1:0] expR;
    doReset();
    aValid = 4'b1010;
    aOutReady = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #2;
      expR = expReadyA();
      nChecks++;
      if (aReady !== expR || aReady[0] !== 1'b0 || aReady[2] !== 1'b0) begin
        nFails++;
        $display("[TB] FAIL sparse_ready cyc=%0d got=%b exp=%b", c, aReady, expR);
      end
      tickA(g);
      nChecks++;
      if (aOutValid !== mOV || aOut !== mOut || aSel !== 2'(mSel)) begin
        nFails++;
        $display("[TB] FAIL sparse_out cyc=%0d got v=%b d=%h s=%0d exp v=%b d=%h s=%0d",
                 c, aOutValid, aOut, aSel, mOV, mOut, mSel);
      end
    end
  endtask

  task automatic test_backpressure();
    int g;
    logic [NA-1:0] expR;
    logic [WA-1:0] heldOut;
    logic [1:0]    heldSel;
    aValid = '1;
    heldOut = '0;
    heldSel = '0;
    for (int c = 0; c < 12; c++) begin
      aOutReady = !(c >= 3 && c < 7);
      #2;
      expR = expReadyA();
      nChecks++;
      if (aReady !== expR || (!aOutReady && aReady !== '0)) begin
        nFails++;
        $display("[TB] FAIL bp_ready cyc=%0d got=%b exp=%b", c, aReady, expR);
      end
      tickA(g);
      if (g >= 0) aData[g] = aData[g] + 8'h10;
      nChecks++;
      if (aOutValid !== mOV || aOut !== mOut || aSel !== 2'(mSel)) begin
        nFails++;
        $display("[TB] FAIL bp_out cyc=%0d got v=%b d=%h s=%0d exp v=%b d=%h s=%0d",
                 c, aOutValid, aOut, aSel, mOV, mOut, mSel);
      end
      if (c == 2) begin
        heldOut = mOut;
        heldSel = 2'(mSel);
      end
      if (c >= 3 && c < 7) begin
        nChecks++;
        if (aOutValid !== 1'b1 || aOut !== heldOut || aSel !== heldSel) begin
          nFails++;
          $display("[TB] FAIL bp_hold cyc=%0d got v=%b d=%h s=%0d exp v=1 d=%h s=%0d",
                   c, aOutValid, aOut, aSel, heldOut, heldSel);
        end
      end
    end
  endtask

  task automatic test_random();
    int g;
    logic [NA-1:0] expR;
    for (int c = 0; c < 80; c++) begin
      aOutReady = ($urandom_range(0, 3) != 0);
      #2;
      expR = expReadyA();
      nChecks++;
      if (aReady !== expR) begin
        nFails++;
        $display("[TB] FAIL rand_ready cyc=%0d got=%b exp=%b", c, aReady, expR);
      end
      tickA(g);
      nChecks++;
      if (aOutValid !== mOV || aOut !== mOut || aSel !== 2'(mSel)) begin
        nFails++;
        $display("[TB] FAIL rand_out cyc=%0d got v=%b d=%h s=%0d exp v=%b d=%h s=%0d",
                 c, aOutValid, aOut, aSel, mOV, mOut, mSel);
      end
      for (int i = 0; i < NA; i++) begin
        if (i == g || !aValid[i]) begin
          aValid[i] = 1'($urandom_range(0, 1));
          aData[i] = 8'($urandom);
        end
      end
    end
  endtask

  task automatic test_fixed_pair();
    int g;
    logic [NA-1:0] expR;
    doReset();
    aOutReady = 1'b1;
    aValid = 4'b0101;
    for (int i = 0; i < NA; i++) aData[i] = 8'hC0 + 8'(i);
    for (int c = 0; c < 8; c++) begin
      if (c == 5) aValid[0] = 1'b0;
      #2;
      expR = expReadyA();
      nChecks++;
      if (aReady !== expR) begin
        nFails++;
        $display("[TB] FAIL pair_ready cyc=%0d got=%b exp=%b", c, aReady, expR);
      end
      tickA(g);
      nChecks++;
      if (aOutValid !== mOV || aOut !== mOut || aSel !== 2'(mSel)) begin
        nFails++;
        $display("[TB] FAIL pair_out cyc=%0d got v=%b d=%h s=%0d exp v=%b d=%h s=%0d",
                 c, aOutValid, aOut, aSel, mOV, mOut, mSel);
      end
`ifdef RR_MUXN_FIXED_PRIORITY_EN
      nChecks++;
      if (aSel !== ((c < 5) ? 2'd0 : 2'd2)) begin
        nFails++;
        $display("[TB] FAIL pair_fixed cyc=%0d got s=%0d exp s=%0d", c, aSel, (c < 5) ? 0 : 2);
      end
`endif
    end
    aValid = '0;
  endtask

  task automatic test_wrap3();
    int es;
    bValid = '1;
    bOutReady = 1'b1;
    for (int c = 0; c < 7; c++) begin
`ifdef RR_MUXN_FIXED_PRIORITY_EN
      es = 0;
`else
      es = c % NB;
`endif
      #2;
      nChecks++;
      if (bReady !== 3'(1 << es)) begin
        nFails++;
        $display("[TB] FAIL wrap_ready cyc=%0d got=%b exp=%b", c, bReady, 3'(1 << es));
      end
      @(posedge clk);
      #1;
      nChecks++;
      if (bOutValid !== 1'b1 || bSel !== 2'(es) || bOut !== 16'hB000 + 16'(es)) begin
        nFails++;
        $display("[TB] FAIL wrap_out cyc=%0d got v=%b d=%h s=%0d exp v=1 d=%h s=%0d",
                 c, bOutValid, bOut, bSel, 16'hB000 + 16'(es), es);
      end
    end
    bValid = '0;
  endtask

  initial begin
    rstN = 1'b0;
    aValid = '0;
    aOutReady = 1'b0;
    bValid = '0;
    bOutReady = 1'b0;
    for (int i = 0; i < NA; i++) aData[i] = '0;
    for (int i = 0; i < NB; i++) bData[i] = '0;
    test_reset();
    test_fairness();
    test_sparse();
    test_backpressure();
    test_random();
    test_fixed_pair();
    test_wrap3();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/rr_muxn.md
# rr_muxn

Registered, round-robin arbitrated N-way multiplexer with valid/ready handshaking on every input channel and on the output. It generalises the combinational N-input selector: the select is not an input but is produced internally by a fair arbiter, and the chosen word is captured in a one-entry output register. It sits wherever several producers share one consumer, such as a shared memory port, a bus master select or a debug/UART funnel.

## Interface
- `INPUT_NUM`, 4: number of input channels; legal range is 2 or more, and non-powers of two are legal.
- `INPUT_SIZE`, 8: data width per channel, in bits.
- `S` (localparam): `$clog2(INPUT_NUM)`.

Ports: one clock; reset is synchronous and active-low.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `in`  in  `INPUT_NUM*INPUT_SIZE`  packed channel data; channel i occupies `[INPUT_SIZE*(i+1)-1 : INPUT_SIZE*i]`.
- `in_valid`  in  `INPUT_NUM`  per-channel valid.
- `in_ready`  out  `INPUT_NUM`  per-channel ready; at most one bit is high per cycle (one-hot or zero).
- `out`  out  `INPUT_SIZE`  registered output data.
- `out_valid`  out  1  output register holds a word.
- `out_ready`  in  1  consumer accepts the word.
- `out_sel`  out  `S`  index of the channel that supplied `out`; registered alongside `out`.

## Operation
- Define `load = !out_valid || out_ready`.
- When `load` is high and any `in_valid` bit is high:
  - The arbiter picks grant index g.
  - `in_ready[g]` = 1 and all other `in_ready` bits = 0.
  - On the clock edge: `out` <= channel g data, `out_sel` <= g, `out_valid` <= 1.
- When `load` is high and no `in_valid` bit is high:
  - `in_ready` = 0.
  - `out_valid` <= 0; `out` and `out_sel` hold their values.
- When `load` is low (output full and stalled):
  - `in_ready` = 0.
  - `out`, `out_sel` and `out_valid` hold.
- Round-robin arbitration:
  - An internal pointer `ptr` (S bits, range 0..INPUT_NUM-1) gives the highest-priority channel.
  - g is the first valid channel found by searching `ptr`, `ptr+1`, … modulo INPUT_NUM.
  - On each transfer into the register, `ptr` <= (g+1) mod INPUT_NUM. Wrap is from INPUT_NUM-1 to 0, never to 2**S-1.
  - `ptr` holds when no transfer occurs.
- Transfer definitions:
  - An input transfer happens when `in_valid[i] && in_ready[i]`.
  - An output transfer happens when `out_valid && out_ready`.
- `in_ready` depends combinationally on `in_valid`, `out_valid`, `out_ready` and `ptr`. Producers must not make `in_valid` depend on `in_ready`.
- Data from a channel is never dropped or duplicated, and every transfer is accepted exactly once.

## Timing
- Latency is 1 cycle: data accepted at edge k appears on `out` with `out_valid` = 1 after edge k.
- Throughput is one word per cycle while `out_ready` = 1. A simultaneous output transfer and new load in the same cycle is required (no bubble).
- Backpressure: while `out_valid && !out_ready`, every `in_ready` bit is 0 and the output is stable.
- Reset (`rst_n` = 0 at an edge) sets `out_valid` = 0, `out` = 0, `out_sel` = 0 and `ptr` = 0.
- `in_ready` is 0 during any cycle in which `rst_n` is low.
- Reset mid-transfer discards the held word; no transfer is counted in that cycle.
- Input data not accepted may change freely. Once a producer asserts `in_valid`, it holds it and its data until accepted.

## Configuration
- Macro: `RR_MUXN_FIXED_PRIORITY_EN`.
- Defined: fixed priority, where the lowest-index valid channel always wins. `ptr` is removed, or tied to 0 and never updated.
- Undefined (default): round-robin as described above.
- All other behaviour, including timing, reset values and handshake rules, is identical in both builds.

## Test plan
- **Reset:** hold `rst_n` = 0 for 3 cycles with all `in_valid` = 1 -> `out_valid` = 0, `out` = 0, `out_sel` = 0 and `in_ready` = 0 throughout.
- **Fairness:** INPUT_NUM = 4, all channels valid continuously with data 0xA0+i, `out_ready` = 1 -> `out_sel` sequence is 0,1,2,3,0,1,… with `out` = 0xA0,0xA1,0xA2,0xA3,… one per cycle.
- **Sparse requests:** only channels 1 and 3 valid, `ptr` = 0 after reset -> grants 1,3,1,3; channels 0 and 2 never see `in_ready`.
- **Backpressure:** drop `out_ready` for 4 cycles while `out_valid` = 1 -> `out`/`out_sel` stable, all `in_ready` = 0, `ptr` unchanged. On release, the next grant continues the rotation without losing a word.
- **Non-power-of-two wrap:** INPUT_NUM = 3, INPUT_SIZE = 16, all valid -> `out_sel` = 0,1,2,0. The pointer never reaches 3.
- **Fixed-priority build:** with `RR_MUXN_FIXED_PRIORITY_EN` defined and channels 0 and 2 continuously valid -> every output has `out_sel` = 0, and channel 2 is granted only after `in_valid[0]` falls.
